// File: rtl/neuro_arb_pkg.sv
// Shared state encoding and float constants for the activation arbiter.
package neuro_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } arb_state_t;

  localparam logic [31:0] FLOAT_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/activation_arbiter_if.sv
// Requester, activation-unit and result-side handshake bundle of the activation arbiter.
interface activation_arbiter_if
  import neuro_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
);
  logic [NUM_REQ-1:0]       req_STB;
  logic [NUM_REQ-1:0]       req_tp;
  logic [NUM_REQ-1:0]       req_BUSY;
  logic                     op_input_STB;
  logic                     op_tp;
  logic                     op_BUSY;
  logic                     op_output_STB;
  logic [DATA_W-1:0]        op_result;
  logic                     arb_BUSY;
  logic [NUM_REQ-1:0]       res_STB;
  logic [DATA_W-1:0]        res_data;
  logic [NUM_REQ-1:0]       res_BUSY;
  logic [NUM_REQ*CNT_W-1:0] perf_cnt;

  // Arbiter side
  modport slave (
    input  req_STB, req_tp, op_BUSY, op_output_STB, op_result, res_BUSY,
    output req_BUSY, op_input_STB, op_tp, arb_BUSY, res_STB, res_data, perf_cnt
  );

  // Requesters, activation unit and result consumers
  modport master (
    output req_STB, req_tp, op_BUSY, op_output_STB, op_result, res_BUSY,
    input  req_BUSY, op_input_STB, op_tp, arb_BUSY, res_STB, res_data, perf_cnt
  );
endinterface

// File: rtl/activation_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);
  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the candidate closest to rr_ptr overwrites the rest.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one step-activation unit among NUM_REQ requesters.
// Optional saturating per-requester completion counters: define ARB_PERF_CNT_EN.
module activation_arbiter
  import neuro_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  activation_arbiter_if.slave bus
);
  localparam int unsigned      IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               op_stb_q, op_stb_d;
  logic               op_tp_q, op_tp_d;
  logic [NUM_REQ-1:0] res_stb_q, res_stb_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic [NUM_REQ-1:0] req_busy_c;
  logic               arb_busy_c;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req_STB),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      op_stb_q   <= 1'b0;
      op_tp_q    <= 1'b0;
      res_stb_q  <= '0;
      res_data_q <= DATA_W'(FLOAT_ZERO);
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      op_stb_q   <= op_stb_d;
      op_tp_q    <= op_tp_d;
      res_stb_q  <= res_stb_d;
      res_data_q <= res_data_d;
    end
  end

  // One transaction in flight: grant, issue to the unit, capture, deliver.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    op_stb_d   = op_stb_q;
    op_tp_d    = op_tp_q;
    res_stb_d  = res_stb_q;
    res_data_d = res_data_q;
    req_busy_c = '1;
    arb_busy_c = 1'b1;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          req_busy_c = ~(NUM_REQ'(1) << pick_idx);
          gnt_d      = pick_idx;
          op_tp_d    = bus.req_tp[pick_idx];
          op_stb_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.op_BUSY) begin
          op_stb_d = 1'b0;
          state_d  = WAIT_RES;
        end
      end
      WAIT_RES: begin
        arb_busy_c = 1'b0;
        if (bus.op_output_STB) begin
          res_data_d = bus.op_result;
          res_stb_d  = NUM_REQ'(1) << gnt_q;
          state_d    = DELIVER;
        end
      end
      DELIVER: begin
        if (!bus.res_BUSY[gnt_q]) begin
          res_stb_d = '0;
          rr_ptr_d  = (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces every requester and the unit's result path to back off.
  assign bus.req_BUSY     = rst ? '1 : req_busy_c;
  assign bus.arb_BUSY     = rst | arb_busy_c;
  assign bus.op_input_STB = op_stb_q;
  assign bus.op_tp        = op_tp_q;
  assign bus.res_STB      = res_stb_q;
  assign bus.res_data     = res_data_q;

`ifdef ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] perf_q;
  logic                          deliver_done;

  assign deliver_done = (state_q == DELIVER) && !bus.res_BUSY[gnt_q];

  // Saturating completion count per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (deliver_done) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_q == IDX_W'(i) && perf_q[i] != '1) begin
          perf_q[i] <= perf_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.perf_cnt = perf_q;
`else
  assign bus.perf_cnt = {(NUM_REQ*CNT_W){1'b0}};
`endif

endmodule
